line_buffer_5x5: RTL and testbench
==================================

Name: line_buffer_5x5

Overview:
- Streaming row buffer directly upstream of the 5x5 window buffer.
- Accepts a raster pixel stream, one pixel per valid cycle, and stores the four previous image lines.
- Each valid pixel produces five vertically aligned pixels of one column, S1 (oldest row) to S5 (current row), which feed the window buffer's S1_i..S5_i inputs.
- Tracks column and row position, and signals when the output column is valid and when the frame ends.

Parameters:
- COLS, 640: pixels per line; 5 or more.
- ROWS, 480: lines per frame; 5 or more.
- DATA_WIDTH, 8: pixel width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- data_valid_i  input  1  data_i holds a valid pixel this cycle.
- sof_i  input  1  start of frame; qualified by data_valid_i; marks the pixel at column 0, row 0.
- data_i  input  DATA_WIDTH  pixel in raster order.
- S1_o  output  DATA_WIDTH  pixel from line r-4, same column.
- S2_o  output  DATA_WIDTH  pixel from line r-3.
- S3_o  output  DATA_WIDTH  pixel from line r-2.
- S4_o  output  DATA_WIDTH  pixel from line r-1.
- S5_o  output  DATA_WIDTH  current pixel from line r.
- valid_o  output  1  S1_o..S5_o form a valid column.
- col_o  output  clog2(COLS)  column index of the current output.
- row_o  output  clog2(ROWS)  row index r of the current output.
- frame_done_o  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, counters and output registers go to 0; FSM goes to IDLE. Line memories are not cleared, because refill overwrites them before use.
- Storage: four line memories LM0..LM3, each COLS x DATA_WIDTH, indexed by the column counter.
- Cascade write on each valid cycle at column c:
  - LM0[c] <= data_i
  - LM1[c] <= LM0[c]
  - LM2[c] <= LM1[c]
  - LM3[c] <= LM2[c]
  - All read-before-write (old values are used).
- Output mapping, registered on the same edge:
  - S5_o <= data_i
  - S4_o <= LM0[c]
  - S3_o <= LM1[c]
  - S2_o <= LM2[c]
  - S1_o <= LM3[c]
- Latency: 1 cycle from data_valid_i to the output registers.
- When data_valid_i=0: counters, memories and S*_o hold their values; valid_o=0 and frame_done_o=0. Gaps of any length are allowed.
- Counters:
  - col_cnt increments per valid pixel and wraps from COLS-1 to 0.
  - On that wrap, row_cnt increments; it wraps from ROWS-1 to 0.
  - col_o and row_o register col_cnt and row_cnt alongside the data.
- FSM states:
  - IDLE: waiting for the first pixel. Any valid pixel moves to FILL; sof_i is not required in IDLE.
  - FILL: rows 0..3; valid_o=0. Moves to STREAM when the last pixel of row 3 is accepted.
  - STREAM: rows 4..ROWS-1; valid_o=1 exactly one cycle after each accepted pixel. The last pixel (col COLS-1, row ROWS-1) moves to DONE.
  - DONE: one cycle; frame_done_o=1, then IDLE. An input pixel arriving during DONE is accepted as col 0, row 0 of the next frame and the FSM goes to FILL. frame_done_o still pulses.
- sof_i with data_valid_i in any state other than IDLE (mid-frame resync):
  - Pixel written at column 0; col_cnt becomes 1, row_cnt becomes 0; FSM goes to FILL.
  - valid_o for that pixel is 0.
  - No frame_done_o pulse.
  - Stale line contents are discarded by the four-line refill.
- sof_i without data_valid_i is ignored.
- No backpressure: the downstream stage must accept every valid_o beat.
- Reset mid-frame: immediate return to IDLE; the next pixel is treated as col 0, row 0.
- Counter widths: clog2 of the respective parameter, minimum 1. Comparisons use the parameter minus 1, without overflow.

Test Plan (COLS=5, ROWS=6, DATA_WIDTH=8 unless stated):
- Reset: rst=0 for 3 cycles while toggling data_i → all outputs 0; release, no input → valid_o stays 0.
- Continuous frame, pixel value = 10*row+col → valid_o first rises 1 cycle after pixel (row 4, col 0), with S1..S5 = 0,10,20,30,40. At (row 5, col 4): S1..S5 = 14,24,34,44,54. Exactly 10 valid_o beats in total.
- Frame end → frame_done_o high for exactly 1 cycle, 1 cycle after pixel 54. A second frame sent back-to-back gives valid_o=0 for its rows 0..3 and correct columns from row 4.
- Random gaps, data_valid_i 50% → same S1..S5 sequence as the continuous case; valid_o never high in a gap cycle; outputs hold during gaps.
- Mid-frame sof_i at (row 4, col 2) → row_o/col_o restart at 0; no valid_o until the new row 4; no frame_done_o pulse.
- Asynchronous reset asserted mid-STREAM between clock edges → outputs 0 immediately; the next frame is processed correctly from IDLE.

Source files
------------

// File: rtl/line_buffer_5x5_if.sv
// Pixel-stream input and column output bundle for the 5-line row buffer.
interface line_buffer_5x5_if #(
    parameter int unsigned COLS       = 640,
    parameter int unsigned ROWS       = 480,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    // raster input stream
    logic                  data_valid_i;
    logic                  sof_i;
    logic [DATA_WIDTH-1:0] data_i;

    // vertically aligned column towards the window buffer
    logic [DATA_WIDTH-1:0] S1_o;
    logic [DATA_WIDTH-1:0] S2_o;
    logic [DATA_WIDTH-1:0] S3_o;
    logic [DATA_WIDTH-1:0] S4_o;
    logic [DATA_WIDTH-1:0] S5_o;
    logic                  valid_o;
    logic [COL_W-1:0]      col_o;
    logic [ROW_W-1:0]      row_o;
    logic                  frame_done_o;

    // line buffer side
    modport slave (
        input  data_valid_i, sof_i, data_i,
        output S1_o, S2_o, S3_o, S4_o, S5_o, valid_o, col_o, row_o, frame_done_o
    );

    // pixel source / column consumer side
    modport master (
        output data_valid_i, sof_i, data_i,
        input  S1_o, S2_o, S3_o, S4_o, S5_o, valid_o, col_o, row_o, frame_done_o
    );
endinterface

// File: rtl/line_buffer_5x5.sv
// Four-line cascaded row buffer: turns a raster pixel stream into 5-pixel
// vertical columns (oldest row on S1, current row on S5) for a 5x5 window.
module line_buffer_5x5 #(
    parameter int unsigned COLS       = 640,
    parameter int unsigned ROWS       = 480,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    line_buffer_5x5_if.slave bus
);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] FILL_LAST = ROW_W'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    logic [DATA_WIDTH-1:0] lm0 [COLS];
    logic [DATA_WIDTH-1:0] lm1 [COLS];
    logic [DATA_WIDTH-1:0] lm2 [COLS];
    logic [DATA_WIDTH-1:0] lm3 [COLS];

    logic             accept;
    logic             resync;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] cur_row;
    logic             col_wrap;
    logic             frame_last;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic             valid_nxt;
    logic             done_nxt;

    logic [DATA_WIDTH-1:0] s1_q;
    logic [DATA_WIDTH-1:0] s2_q;
    logic [DATA_WIDTH-1:0] s3_q;
    logic [DATA_WIDTH-1:0] s4_q;
    logic [DATA_WIDTH-1:0] s5_q;
    logic                  valid_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic                  done_q;

    // Position of the pixel accepted this cycle; sof restarts at column 0, row 0
    always_comb begin
        accept     = bus.data_valid_i;
        resync     = bus.data_valid_i && bus.sof_i;
        wr_col     = resync ? '0 : col_cnt;
        cur_row    = resync ? '0 : row_cnt;
        col_wrap   = (wr_col == COL_LAST);
        frame_last = col_wrap && (cur_row == ROW_LAST);
        col_nxt    = col_wrap ? '0 : wr_col + COL_W'(1);
        row_nxt    = cur_row;
        if (col_wrap) begin
            row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and next values of the valid / frame-done outputs
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    state_nxt = FILL;
                end
                FILL: begin
                    if (!resync && col_wrap && (cur_row == FILL_LAST)) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    if (resync) begin
                        state_nxt = FILL;
                    end else begin
                        valid_nxt = 1'b1;
                        if (frame_last) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // pixel arriving here is column 0, row 0 of the next frame
                    state_nxt = FILL;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end

    // Line memory cascade, read-before-write; contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lm0[wr_col] <= bus.data_i;
            lm1[wr_col] <= lm0[wr_col];
            lm2[wr_col] <= lm1[wr_col];
            lm3[wr_col] <= lm2[wr_col];
        end
    end

    // Position counters and registered column outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            s5_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            if (accept) begin
                col_cnt <= col_nxt;
                row_cnt <= row_nxt;
                s5_q    <= bus.data_i;
                s4_q    <= lm0[wr_col];
                s3_q    <= lm1[wr_col];
                s2_q    <= lm2[wr_col];
                s1_q    <= lm3[wr_col];
                col_q   <= wr_col;
                row_q   <= cur_row;
            end
        end
    end

    assign bus.S1_o         = s1_q;
    assign bus.S2_o         = s2_q;
    assign bus.S3_o         = s3_q;
    assign bus.S4_o         = s4_q;
    assign bus.S5_o         = s5_q;
    assign bus.valid_o      = valid_q;
    assign bus.col_o        = col_q;
    assign bus.row_o        = row_q;
    assign bus.frame_done_o = done_q;

endmodule

// File: tb/tb_line_buffer_5x5.sv
// Directed bench for line_buffer_5x5 with COLS=5, ROWS=6, 8-bit pixels.
// Pixel (r,c) of a frame carries base + 10*r + c, so every output column is
// known in closed form: Sk at row r, column c = base + 10*(r-5+k) + c.
module tb_line_buffer_5x5;
    localparam int unsigned COLS = 5;
    localparam int unsigned ROWS = 6;
    localparam int unsigned DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int tests = 0;
    int fails = 0;
    int beats = 0;
    int last_val = 0;
    int last_c   = 0;
    int last_r   = 0;

    line_buffer_5x5_if #(.COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW)) bus ();

    line_buffer_5x5 #(.COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of input at the falling edge, return just after the rising edge
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        bus.data_valid_i = v;
        bus.sof_i        = s;
        bus.data_i       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, 32'(bus.valid_o), 0);
        check({tag, " done"},  32'(bus.frame_done_o), 0);
        check({tag, " S1"},    32'(bus.S1_o), 0);
        check({tag, " S5"},    32'(bus.S5_o), 0);
        check({tag, " col"},   32'(bus.col_o), 0);
        check({tag, " row"},   32'(bus.row_o), 0);
    endtask

    task automatic send_px(input int r, input int c, input int base, input logic s);
        string t;
        bit    exp_v;
        step(1'b1, s, 8'(base + 10 * r + c));
        t     = $sformatf("b%0d r%0d c%0d", base, r, c);
        exp_v = (r >= 4);
        if (bus.valid_o === 1'b1) beats++;
        check({t, " valid"}, 32'(bus.valid_o), 32'(exp_v));
        check({t, " done"},  32'(bus.frame_done_o), 32'((r == ROWS - 1) && (c == COLS - 1)));
        check({t, " col"},   32'(bus.col_o), 32'(c));
        check({t, " row"},   32'(bus.row_o), 32'(r));
        check({t, " S5"},    32'(bus.S5_o), 32'(base + 10 * r + c));
        if (exp_v) begin
            check({t, " S4"}, 32'(bus.S4_o), 32'(base + 10 * (r - 1) + c));
            check({t, " S3"}, 32'(bus.S3_o), 32'(base + 10 * (r - 2) + c));
            check({t, " S2"}, 32'(bus.S2_o), 32'(base + 10 * (r - 3) + c));
            check({t, " S1"}, 32'(bus.S1_o), 32'(base + 10 * (r - 4) + c));
        end
        last_val = base + 10 * r + c;
        last_c   = c;
        last_r   = r;
    endtask

    // idle cycle: random data and a possibly raised sof must change nothing
    task automatic gap();
        step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        check("gap valid", 32'(bus.valid_o), 0);
        check("gap done",  32'(bus.frame_done_o), 0);
        check("gap S5",    32'(bus.S5_o), 32'(last_val));
        check("gap col",   32'(bus.col_o), 32'(last_c));
        check("gap row",   32'(bus.row_o), 32'(last_r));
    endtask

    task automatic frame(input int base, input bit gaps);
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (gaps) begin
                    for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) gap();
                end
                send_px(r, c, base, (r == 0) && (c == 0));
            end
        end
    endtask

    task automatic idle_after_frame(input string tag);
        step(1'b0, 1'b0, 8'h00);
        check({tag, " idle valid"}, 32'(bus.valid_o), 0);
        check({tag, " idle done"},  32'(bus.frame_done_o), 0);
    endtask

    initial begin
        bus.data_valid_i = 1'b0;
        bus.sof_i        = 1'b0;
        bus.data_i       = '0;

        // reset held while inputs toggle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.data_valid_i = 1'b1;
            bus.sof_i        = 1'($urandom_range(0, 1));
            bus.data_i       = 8'($urandom);
            @(posedge clk);
            #1;
            check_all_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        bus.data_valid_i = 1'b0;
        bus.sof_i        = 1'b0;
        rst              = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_all_zero("post-reset idle");

        // continuous frame, then a second one back-to-back through DONE
        beats = 0;
        frame(0, 1'b0);
        check("frame1 beats", 32'(beats), 10);
        beats = 0;
        frame(100, 1'b0);
        check("frame2 beats", 32'(beats), 10);
        idle_after_frame("frame2");

        // same frame with random idle gaps
        beats = 0;
        frame(0, 1'b1);
        check("gapped beats", 32'(beats), 10);
        idle_after_frame("gapped");

        // sof at row 4 col 2 restarts the frame without a done pulse
        beats = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (r < 4 || c < 2) send_px(r, c, 0, (r == 0) && (c == 0));
            end
        end
        check("partial beats", 32'(beats), 2);
        beats = 0;
        frame(50, 1'b0);
        check("resync beats", 32'(beats), 10);
        idle_after_frame("resync");

        // asynchronous reset between clock edges in the middle of streaming
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (r < 4 || c < 3) send_px(r, c, 0, (r == 0) && (c == 0));
            end
        end
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        bus.data_valid_i = 1'b0;
        bus.sof_i        = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        beats = 0;
        frame(20, 1'b0);
        check("after reset beats", 32'(beats), 10);
        idle_after_frame("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
